risc_toy_mem: RTL and testbench

Word-addressed memory responder that serves both memory ports of the RISC_TOY core: the instruction-fetch port (IREQ/IADDR → INSTR) and the data port (DREQ/DRW/DADDR/DWDATA → DRDATA). It is synchronous with a one-cycle read latency. After reset it runs a clear sequence that zeroes the whole array. A host preload port lets the bench or boot logic load a program before the core runs.

---
 rtl/risc_toy_pkg.sv | 12 +
 rtl/risc_toy_mem_array.sv | 40 ++++
 rtl/risc_toy_mem.sv | 108 ++++++++++
 tb/tb_risc_toy_mem.sv | 197 +++++++++++++++++++
 4 files changed

// File: rtl/risc_toy_pkg.sv
// Shared types and constants for the RISC_TOY memory responder.
package risc_toy_pkg;
  localparam int WORD_W = 32;

  localparam logic DRW_WRITE = 1'b1;
  localparam logic DRW_READ  = 1'b0;

  typedef enum logic {
    CLEAR,
    READY
  } mem_state_t;
endpackage

// File: rtl/risc_toy_mem_array.sv
// Word storage with two registered synchronous read ports and one write port.
// Reads sample the array before the same-edge write lands (read-before-write).
module risc_toy_mem_array
  import risc_toy_pkg::*;
#(
  parameter int AW = 10
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              fetch_en,
  input  logic              fetch_zero,
  input  logic [AW-1:0]     fetch_addr,
  output logic [WORD_W-1:0] fetch_data,
  input  logic              data_en,
  input  logic              data_zero,
  input  logic [AW-1:0]     data_addr,
  output logic [WORD_W-1:0] data_rd,
  input  logic              wr_en,
  input  logic [AW-1:0]     wr_addr,
  input  logic [WORD_W-1:0] wr_data
);
  localparam int DEPTH = 2 ** AW;

  logic [WORD_W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
  end

  // Storage itself is never reset; only the read registers are.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fetch_data <= '0;
      data_rd    <= '0;
    end else begin
      if (fetch_en) fetch_data <= fetch_zero ? '0 : mem[fetch_addr];
      if (data_en)  data_rd    <= data_zero  ? '0 : mem[data_addr];
    end
  end
endmodule

// File: rtl/risc_toy_mem.sv
// Instruction/data memory responder for RISC_TOY: one-cycle read latency, no stalls.
// Clears the whole array after reset (BUSY), then serves fetch, data and preload traffic.
module risc_toy_mem
  import risc_toy_pkg::*;
#(
  parameter int AW = 10
) (
  input  logic              CLK,
  input  logic              RSTN,
  input  logic              IREQ,
  input  logic [29:0]       IADDR,
  output logic [WORD_W-1:0] INSTR,
  input  logic              DREQ,
  input  logic              DRW,
  input  logic [29:0]       DADDR,
  input  logic [WORD_W-1:0] DWDATA,
  output logic [WORD_W-1:0] DRDATA,
  input  logic              LD_EN,
  input  logic [AW-1:0]     LD_ADDR,
  input  logic [WORD_W-1:0] LD_DATA,
  output logic              BUSY,
  output logic              ERR
);
  localparam int DEPTH = 2 ** AW;

  mem_state_t state;
  logic [AW-1:0] clr_cnt;

  logic ready;
  logic i_oor, d_oor;
  logic d_read, d_write;
  logic fetch_en, fetch_zero, data_en, data_zero;
  logic wr_en;
  logic [AW-1:0] wr_addr;
  logic [WORD_W-1:0] wr_data;

  assign ready   = (state == READY);
  assign i_oor   = |IADDR[29:AW];
  assign d_oor   = |DADDR[29:AW];
  assign d_read  = DREQ && (DRW == DRW_READ);
  assign d_write = DREQ && (DRW == DRW_WRITE) && !d_oor;

  // While clearing, both read registers are reloaded with zero every cycle.
  assign fetch_en   = !ready || IREQ;
  assign fetch_zero = !ready || i_oor;
  assign data_en    = !ready || d_read;
  assign data_zero  = !ready || d_oor;

  always_comb begin
    wr_en   = 1'b0;
    wr_addr = '0;
    wr_data = '0;
    if (!ready) begin
      wr_en   = 1'b1;
      wr_addr = clr_cnt;
    end else if (LD_EN) begin
      wr_en   = 1'b1;
      wr_addr = LD_ADDR;
      wr_data = LD_DATA;
    end else if (d_write) begin
      wr_en   = 1'b1;
      wr_addr = DADDR[AW-1:0];
      wr_data = DWDATA;
    end
  end

  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      state   <= CLEAR;
      clr_cnt <= '0;
      BUSY    <= 1'b1;
      ERR     <= 1'b0;
    end else begin
      case (state)
        CLEAR: begin
          clr_cnt <= clr_cnt + AW'(1);
          if (clr_cnt == AW'(DEPTH - 1)) begin
            state <= READY;
            BUSY  <= 1'b0;
          end
        end
        READY: begin
          if ((IREQ && i_oor) || (DREQ && d_oor)) ERR <= 1'b1;
        end
        default: begin
          state <= CLEAR;
          BUSY  <= 1'b1;
        end
      endcase
    end
  end

  risc_toy_mem_array #(.AW(AW)) u_array (
    .clk        (CLK),
    .rst_n      (RSTN),
    .fetch_en   (fetch_en),
    .fetch_zero (fetch_zero),
    .fetch_addr (IADDR[AW-1:0]),
    .fetch_data (INSTR),
    .data_en    (data_en),
    .data_zero  (data_zero),
    .data_addr  (DADDR[AW-1:0]),
    .data_rd    (DRDATA),
    .wr_en      (wr_en),
    .wr_addr    (wr_addr),
    .wr_data    (wr_data)
  );
endmodule

// File: tb/tb_risc_toy_mem.sv
// Bench for risc_toy_mem (AW=4): directed steps plus random traffic against a cycle-level array model.
module tb_risc_toy_mem;
  localparam int AW    = 4;
  localparam int DEPTH = 16;

  logic        CLK = 1'b0;
  logic        RSTN;
  logic        IREQ;
  logic [29:0] IADDR;
  logic [31:0] INSTR;
  logic        DREQ;
  logic        DRW;
  logic [29:0] DADDR;
  logic [31:0] DWDATA;
  logic [31:0] DRDATA;
  logic        LD_EN;
  logic [AW-1:0] LD_ADDR;
  logic [31:0] LD_DATA;
  logic        BUSY;
  logic        ERR;

  int checks = 0;
  int errors = 0;

  logic [31:0] model [DEPTH];
  int          busy_left;
  logic        m_err;
  logic [31:0] e_instr, e_drdata;

  risc_toy_mem #(.AW(AW)) dut (
    .CLK(CLK), .RSTN(RSTN),
    .IREQ(IREQ), .IADDR(IADDR), .INSTR(INSTR),
    .DREQ(DREQ), .DRW(DRW), .DADDR(DADDR), .DWDATA(DWDATA), .DRDATA(DRDATA),
    .LD_EN(LD_EN), .LD_ADDR(LD_ADDR), .LD_DATA(LD_DATA),
    .BUSY(BUSY), .ERR(ERR)
  );

  always #5 CLK = ~CLK;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish (time %0t, limit 2000000)", $time);
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag);
    check({tag, ".instr"},  INSTR,  e_instr);
    check({tag, ".drdata"}, DRDATA, e_drdata);
    check({tag, ".busy"},   {31'b0, BUSY}, {31'b0, busy_left > 0});
    check({tag, ".err"},    {31'b0, ERR},  {31'b0, m_err});
  endtask

  task automatic drive(input logic ireq, input logic [29:0] iaddr,
                       input logic dreq, input logic drw, input logic [29:0] daddr,
                       input logic [31:0] dwdata, input logic ld_en,
                       input logic [AW-1:0] ld_addr, input logic [31:0] ld_data);
    IREQ = ireq; IADDR = iaddr; DREQ = dreq; DRW = drw; DADDR = daddr;
    DWDATA = dwdata; LD_EN = ld_en; LD_ADDR = ld_addr; LD_DATA = ld_data;
  endtask

  task automatic idle();
    drive(1'b0, '0, 1'b0, 1'b0, '0, '0, 1'b0, '0, '0);
  endtask

  // One clock edge: the model consumes the sampled inputs, outputs are checked at the falling edge.
  task automatic step(input string tag);
    logic [31:0] old [DEPTH];
    logic i_out, d_out;
    @(posedge CLK);
    if (busy_left > 0) begin
      model[DEPTH - busy_left] = 32'h0;
      busy_left--;
      e_instr  = 32'h0;
      e_drdata = 32'h0;
    end else begin
      old   = model;
      i_out = (IADDR >> AW) != 0;
      d_out = (DADDR >> AW) != 0;
      if (IREQ) begin
        e_instr = i_out ? 32'h0 : old[IADDR % DEPTH];
        if (i_out) m_err = 1'b1;
      end
      if (DREQ && !DRW) e_drdata = d_out ? 32'h0 : old[DADDR % DEPTH];
      if (DREQ && d_out) m_err = 1'b1;
      if (LD_EN) model[LD_ADDR] = LD_DATA;
      else if (DREQ && DRW && !d_out) model[DADDR % DEPTH] = DWDATA;
    end
    @(negedge CLK);
    check_all(tag);
  endtask

  task automatic do_reset();
    RSTN = 1'b0;
    busy_left = DEPTH;
    m_err    = 1'b0;
    e_instr  = 32'h0;
    e_drdata = 32'h0;
    #1;
    check_all("reset");
    @(negedge CLK);
    @(negedge CLK);
    RSTN = 1'b1;
  endtask

  task automatic random_stim(input int oor_pct);
    logic [29:0] ia, da;
    ia = 30'($urandom_range(0, DEPTH - 1));
    da = 30'($urandom_range(0, DEPTH - 1));
    if ($urandom_range(0, 99) < oor_pct) ia = ia | (30'd1 << $urandom_range(AW, 29));
    if ($urandom_range(0, 99) < oor_pct) da = da | (30'd1 << $urandom_range(AW, 29));
    drive(1'($urandom_range(0, 1)), ia, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
          da, $urandom, ($urandom_range(0, 3) == 0), AW'($urandom_range(0, DEPTH - 1)), $urandom);
  endtask

  initial begin
    idle();
    RSTN = 1'b0;
    @(negedge CLK);
    do_reset();

    // Clear phase with requests flying: they must all read back as zero.
    for (int i = 0; i < DEPTH; i++) begin
      random_stim(0);
      step("clear");
      if (i == DEPTH - 2) check("busy_before_last", {31'b0, BUSY}, 32'd1);
    end
    check("busy_after_clear", {31'b0, BUSY}, 32'd0);
    for (int a = 0; a < DEPTH; a++) begin
      drive(1'b1, 30'(a), 1'b1, 1'b0, 30'(DEPTH - 1 - a), '0, 1'b0, '0, '0);
      step("zero_read");
      check("zero_instr", INSTR, 32'h0);
      check("zero_drdata", DRDATA, 32'h0);
    end

    drive(1'b0, '0, 1'b0, 1'b0, '0, '0, 1'b1, 4'd3, 32'hDEADBEEF); step("ld3");
    drive(1'b0, '0, 1'b0, 1'b0, '0, '0, 1'b1, 4'd4, 32'h12345678); step("ld4");
    drive(1'b1, 30'd3, 1'b0, 1'b0, '0, '0, 1'b0, '0, '0);          step("fetch3");
    check("instr3", INSTR, 32'hDEADBEEF);
    drive(1'b1, 30'd4, 1'b0, 1'b0, '0, '0, 1'b0, '0, '0);          step("fetch4");
    check("instr4", INSTR, 32'h12345678);

    drive(1'b1, 30'd7, 1'b1, 1'b1, 30'd7, 32'hA5A5A5A5, 1'b0, '0, '0); step("wr7");
    check("instr_old7", INSTR, 32'h0);
    drive(1'b0, '0, 1'b1, 1'b0, 30'd7, '0, 1'b0, '0, '0); step("rd7");
    check("drdata7", DRDATA, 32'hA5A5A5A5);

    drive(1'b0, '0, 1'b1, 1'b1, 30'd5, 32'h2, 1'b1, 4'd5, 32'h1); step("conflict");
    drive(1'b0, '0, 1'b1, 1'b0, 30'd5, '0, 1'b0, '0, '0);          step("rd5");
    check("drdata5", DRDATA, 32'h1);
    check("err_conflict", {31'b0, ERR}, 32'd0);

    for (int i = 0; i < 300; i++) begin
      random_stim(0);
      step("rand_inrange");
    end

    drive(1'b0, '0, 1'b1, 1'b1, 30'h10, 32'hFF, 1'b0, '0, '0); step("oor_wr");
    check("err_set", {31'b0, ERR}, 32'd1);
    drive(1'b1, 30'h20, 1'b1, 1'b0, 30'd0, '0, 1'b0, '0, '0); step("oor_fetch");
    check("instr_oor", INSTR, 32'h0);
    check("drdata_addr0", DRDATA, model[0]);
    for (int i = 0; i < 200; i++) begin
      random_stim(15);
      step("rand_oor");
    end
    check("err_sticky", {31'b0, ERR}, 32'd1);

    idle();
    do_reset();
    for (int i = 0; i < 8; i++) begin
      random_stim(10);
      step("clear_a");
    end
    do_reset();
    check("err_cleared", {31'b0, ERR}, 32'd0);
    for (int i = 0; i < DEPTH; i++) begin
      random_stim(10);
      step("clear_b");
    end
    check("busy_after_reclear", {31'b0, BUSY}, 32'd0);
    for (int i = 0; i < 100; i++) begin
      random_stim(5);
      step("rand_final");
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
